// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared FSM state type and width helpers for the accumulating adder tree
package adder_ctrl_pkg;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic int tree_w(input int n, input int dataw);
    return $clog2(n) + dataw;
  endfunction
  function automatic int acc_w(input int n, input int dataw, input int max_beats);
    return tree_w(n, dataw) + $clog2(max_beats);
  endfunction
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction
endpackage

// File: rtl/adder_tree.sv
// adder_tree: combinational signed sum of N packed DATAW-bit elements
module adder_tree import adder_ctrl_pkg::*; #(
  parameter int N     = 64,
  parameter int DATAW = 8,
  parameter int TREEW = tree_w(N, DATAW)
) (
  input  logic [N*DATAW-1:0]       data_i,
  output logic signed [TREEW-1:0]  sum_o
);
  // sign-extend each element to the full tree width and reduce
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N; k++) sum_o = sum_o + TREEW'(signed'(data_i[k*DATAW +: DATAW]));
  end
endmodule

// File: rtl/adder_tree_accum_ctrl.sv
// adder_tree_accum_ctrl: sums multi-beat signed vectors through one adder tree into a valid/ready result
module adder_tree_accum_ctrl import adder_ctrl_pkg::*; #(
  parameter int N         = 64,
  parameter int DATAW     = 8,
  parameter int MAX_BEATS = 16,
  parameter int TREEW     = tree_w(N, DATAW),
  parameter int ACCW      = acc_w(N, DATAW, MAX_BEATS),
  parameter int CNTW      = cnt_w(MAX_BEATS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [CNTW-1:0]        cfg_beats_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N*DATAW-1:0]     in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic signed [ACCW-1:0] out_sum_o,
  output logic                   busy_o
);
  state_e                 state_q;
  logic [CNTW-1:0]        beat_cnt_q, eff_beats_q, cfg_eff;
  logic                   rdy_q, psum_vld_q, psum_last_q, out_valid_q;
  logic                   stall, accept, last_tag, fire;
  logic signed [TREEW-1:0] tree_sum;
  logic signed [ACCW-1:0] psum_q, acc_q, acc_next, out_sum_q;

  adder_tree #(.N(N), .DATAW(DATAW), .TREEW(TREEW)) u_tree (
    .data_i (in_data_i),
    .sum_o  (tree_sum)
  );

  // handshake, last-beat tagging and accumulator arithmetic; rdy_q keeps ready low while in reset
  always_comb begin
    cfg_eff     = (cfg_beats_i == '0) ? CNTW'(1) : (cfg_beats_i > CNTW'(MAX_BEATS)) ? CNTW'(MAX_BEATS) : cfg_beats_i;
    stall       = psum_vld_q & psum_last_q & out_valid_q & ~out_ready_i;
    in_ready_o  = rdy_q & ~stall & ~flush_i;
    accept      = in_valid_i & in_ready_o;
    last_tag    = (state_q == IDLE) ? (cfg_eff == CNTW'(1)) : (beat_cnt_q + CNTW'(1) == eff_beats_q);
    fire        = psum_vld_q & ~stall;
    acc_next    = acc_q + psum_q;
  end

  // beat sequencing: latch the vector length on its first beat, count the rest
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      eff_beats_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush_i) begin
        state_q    <= IDLE;
        beat_cnt_q <= '0;
      end else if (accept) begin
        if (state_q == IDLE) begin
          eff_beats_q <= cfg_eff;
          beat_cnt_q  <= CNTW'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + CNTW'(1);
        end
        state_q <= last_tag ? IDLE : ACCUM;
      end
    end
  end

  // stage 1: register the tree sum of each accepted beat, holding while the last partial is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
      psum_last_q <= 1'b0;
    end else if (flush_i) begin
      psum_vld_q <= 1'b0;
    end else if (accept) begin
      psum_q      <= ACCW'(tree_sum);
      psum_vld_q  <= 1'b1;
      psum_last_q <= last_tag;
    end else if (!stall) begin
      psum_vld_q <= 1'b0;
    end
  end

  // stage 2: accumulate partials and publish the vector sum on the last one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (fire) acc_q <= psum_last_q ? '0 : acc_next;
      if (fire && psum_last_q) begin
        out_sum_q   <= acc_next;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign busy_o      = (state_q != IDLE) | psum_vld_q | out_valid_q;
endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// tb_adder_tree_accum_ctrl: directed checks of the accumulating adder tree controller
module tb_adder_tree_accum_ctrl;
  localparam int N = 4, DATAW = 8, MAX_BEATS = 4, ACCW = 12, CNTW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [CNTW-1:0]        cfg_beats;
  logic [N*DATAW-1:0]     in_data;
  logic signed [ACCW-1:0] out_sum;
  int                     passed = 0, total = 0;

  adder_tree_accum_ctrl #(.N(N), .DATAW(DATAW), .MAX_BEATS(MAX_BEATS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .cfg_beats_i (cfg_beats),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  function automatic logic [N*DATAW-1:0] pack(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_beats = '0; in_data = '0;
    #22;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 1);
    // partial vector cut short by reset
    cfg_beats = 3'd4; in_valid = 1'b1; in_data = pack(1, 1, 1, 1);
    step();
    step();
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    #2 rst_n = 1'b1;
    step();
    chk("mid_post_ready", 32'(in_ready), 1);
    // three-beat vector of ones; cfg changes after the first beat must be ignored
    cfg_beats = 3'd3; in_valid = 1'b1; in_data = pack(1, 1, 1, 1); out_ready = 1'b1;
    step();
    cfg_beats = 3'd1;
    step();
    step();
    in_valid = 1'b0;
    chk("b3_not_yet", 32'(out_valid), 0);
    step();
    chk("b3_valid", 32'(out_valid), 1);
    chk("b3_sum", 32'(out_sum), 12);
    chk("b3_busy", 32'(busy), 1);
    step();
    chk("b3_cleared", 32'(out_valid), 0);
    chk("b3_idle", 32'(busy), 0);
    // signed extreme: 16 elements of -128
    cfg_beats = 3'd4; in_valid = 1'b1; in_data = pack(8'h80, 8'h80, 8'h80, 8'h80);
    repeat (4) step();
    in_valid = 1'b0;
    step();
    chk("ext_valid", 32'(out_valid), 1);
    chk("ext_sum", 32'(out_sum), -2048);
    chk("ext_raw", {20'd0, out_sum}, 32'h800);
    step();
    // backpressure: A=10 held while B=20 waits in stage 1
    out_ready = 1'b0; cfg_beats = 3'd1; in_valid = 1'b1; in_data = pack(1, 2, 3, 4);
    step();
    in_data = pack(5, 5, 5, 5);
    chk("bp_ready_a", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bp_a_valid", 32'(out_valid), 1);
    chk("bp_a_sum", 32'(out_sum), 10);
    chk("bp_stall", 32'(in_ready), 0);
    step();
    chk("bp_a_hold", 32'(out_sum), 10);
    chk("bp_still_stall", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_unstall", 32'(in_ready), 1);
    step();
    chk("bp_b_valid", 32'(out_valid), 1);
    chk("bp_b_sum", 32'(out_sum), 20);
    step();
    chk("bp_drained", 32'(out_valid), 0);
    // flush after two of four beats, then a clean 2-beat vector of twos
    cfg_beats = 3'd4; in_valid = 1'b1; in_data = pack(3, 3, 3, 3);
    step();
    step();
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 0);
    cfg_beats = 3'd2; in_data = pack(2, 2, 2, 2);
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("fl_valid", 32'(out_valid), 1);
    chk("fl_sum", 32'(out_sum), 16);
    step();
    // zero config: back-to-back single-beat vectors, one result per cycle
    cfg_beats = 3'd0; in_valid = 1'b1; in_data = pack(1, 1, 1, 1);
    step();
    in_data = pack(2, 2, 2, 2);
    step();
    in_data = pack(3, 3, 3, 3);
    chk("z1_sum", 32'(out_sum), 4);
    step();
    in_data = pack(4, 4, 4, 4);
    chk("z2_sum", 32'(out_sum), 8);
    step();
    in_valid = 1'b0;
    chk("z3_sum", 32'(out_sum), 12);
    chk("z3_valid", 32'(out_valid), 1);
    step();
    chk("z4_sum", 32'(out_sum), 16);
    chk("z4_valid", 32'(out_valid), 1);
    step();
    chk("z_done", 32'(out_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adder_tree_accum_ctrl.md
Name: adder_tree_accum_ctrl

Overview:
- Sequences one shared `adder_tree` instance to reduce long signed vectors delivered as a stream of N-element beats.
- Each beat is summed by the tree, registered, and accumulated over a run-time-configured beat count.
- The final vector sum is presented on a valid/ready output.
- Sits between the spin/weight streaming front-end and the energy/local-field consumers.

Parameters:
- N, 64, elements per beat (tree width); power of two, at least 2.
- DATAW, 8, signed bit width of each element.
- MAX_BEATS, 16, maximum beats per vector; power of two, at least 2.
- TREEW, $clog2(N)+DATAW, tree output width (derived).
- ACCW, TREEW+$clog2(MAX_BEATS), accumulator/result width (derived).
- CNTW, $clog2(MAX_BEATS)+1, beat-count width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of all in-flight work
- cfg_beats_i  in  CNTW  beats in the next vector; sampled on the first beat of each vector
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat ready
- in_data_i  in  N*DATAW  packed signed elements; element k is bits [k*DATAW +: DATAW]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result ready
- out_sum_o  out  ACCW  signed vector sum, stable while out_valid_o && !out_ready_i
- busy_o  out  1  high while any beat or result is held

Behaviour:
- Clock and reset:
  - One clock, clk_i; reset rst_ni is asynchronous, active-low.
  - Reset clears every register: all outputs 0, FSM in IDLE, counters 0.
  - in_ready_o is 0 during reset and 1 in the first cycle after release.
- FSM (beat sequencing):
  - IDLE: on an accepted beat, latch eff_beats = max(cfg_beats_i, 1), capped at MAX_BEATS; set beat_cnt = 1.
    - If eff_beats == 1, the beat is tagged last and the FSM stays in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM: each accepted beat increments beat_cnt. The beat where beat_cnt+1 == eff_beats is tagged last, and the FSM returns to IDLE.
  - cfg_beats_i is ignored outside the first beat of a vector.
- Stage 1 (registered tree output):
  - On an accepted beat, psum_q <= tree sum (sign-extended to ACCW), psum_vld_q <= 1, psum_last_q <= last tag.
  - Otherwise psum_vld_q <= 0, unless stage 1 is stalled, in which case it holds.
- Stage 2 (accumulate):
  - When psum_vld_q and not stalled: acc_next = acc_q + psum_q.
  - If psum_last_q: out_sum_q <= acc_next, out_valid_q <= 1, acc_q <= 0.
  - Otherwise acc_q <= acc_next.
- Stall and backpressure:
  - stall = psum_vld_q & psum_last_q & out_valid_q & ~out_ready_i.
  - in_ready_o = ~(stall & psum_vld_q), i.e. ~stall.
  - Non-last partials never stall.
  - out_valid_q clears on the handshake unless a new result is written in the same cycle; in that case the new result replaces it and valid stays high.
- Latency: last beat accepted in cycle t gives out_valid_o in cycle t+2.
- Throughput: one beat per cycle. Back-to-back single-beat vectors sustain one result per cycle while out_ready_i is held high.
- Width: ACCW is sized so that MAX_BEATS*N elements of value -2^(DATAW-1) cannot overflow; no saturation logic.
- flush_i (synchronous, priority over all other updates):
  - Clears FSM, beat_cnt, psum_vld_q, acc_q and out_valid_q; any pending result is dropped.
  - in_ready_o is forced 0 in the flush cycle; beats presented then are not accepted.
- Reset mid-vector: identical to flush, but asynchronous.
- busy_o = (state != IDLE) | psum_vld_q | out_valid_q.

Decomposition:
- Package `adder_ctrl_pkg`:
  - FSM state enum (IDLE, ACCUM).
  - Width helper functions for TREEW, ACCW and CNTW.
- One sub-module: the existing `adder_tree`, instantiated with N and DATAW and fed directly from in_data_i.
- Counters, FSM and accumulator stay in this module.

Test Plan (N=4, DATAW=8, MAX_BEATS=4):
- Reset:
  - Stimulus: assert rst_ni=0 mid-stream, then release.
  - Response: all outputs 0 during reset; in_ready_o=1 one cycle after release; no result emitted for the partial vector.
- Three-beat vector:
  - Stimulus: cfg_beats_i=3; three beats of all elements = 1.
  - Response: out_sum_o = 12 exactly two cycles after the third beat; busy_o falls after the handshake.
- Signed extreme:
  - Stimulus: cfg_beats_i=4; all elements = -128 for 4 beats.
  - Response: out_sum_o = -2048 (ACCW = 12 bits, 0x800), no wrap.
- Backpressure:
  - Stimulus: out_ready_i=0; vector A (1 beat, sum 10), then vector B (1 beat, sum 20).
  - Response: in_ready_o drops while B's last partial waits; A is held stable; after out_ready_i=1, A then B (20) are delivered in order.
- Flush:
  - Stimulus: flush_i pulsed after 2 of 4 beats; then a new 2-beat vector of all 2s.
  - Response: result is 16, with no contamination from the flushed beats.
- Zero config:
  - Stimulus: cfg_beats_i=0; back-to-back single beats with element values 1,2,3,4 each.
  - Response: results 4, 8, 12, 16 on consecutive cycles.
